irq_pending_capture: RTL and testbench
======================================

Name: irq_pending_capture

Overview:
- Upstream capture stage for the 16-input priority encoder.
- Synchronises 16 raw request lines and detects their rising edges.
- Latches masked edges into a sticky pending vector, and presents that vector plus an encoder-format code for the highest pending request.
- A service handshake clears the highest-priority pending bit, so lower requests are then exposed in order.

Parameters:
- WIDTH, 16, number of request lines (code format assumes WIDTH <= 16).
- SYNC_STAGES, 2, flops in each input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  capture/service enable; low freezes pending and overflow state.
- req_in  in  WIDTH  raw asynchronous request lines; bit WIDTH-1 is highest priority.
- mask_i  in  WIDTH  1 = edge on this line may set pending; 0 = edge ignored.
- svc_ack_i  in  1  single-cycle pulse: the current highest pending request has been serviced.
- clear_i  in  1  synchronous clear of all pending and overflow bits.
- pending_o  out  WIDTH  registered pending vector (feeds the encoder input).
- irq_o  out  1  OR of pending_o.
- code_o  out  8  index of the highest set pending bit in bits [3:0], bits [7:4] = 0; 8'hF0 when nothing is pending.
- overflow_o  out  WIDTH  sticky: a new edge arrived on a line that was already pending.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All flops reset to 0.
- Reset values: pending_o=0, overflow_o=0, irq_o=0, code_o=8'hF0.
- Synchroniser: each req_in bit passes through SYNC_STAGES flops (s). A further flop holds s_d. rise = s & ~s_d.
  - Synchronisers and s_d always run, independent of ena. Edges while ena=0 are lost, not deferred.
- Capture latency: req_in is stable high before clock edge E0 → pending bit is set at edge E(SYNC_STAGES), i.e. E2 by default.
  - A pulse shorter than one clk period may be missed; the source must guarantee >= 1 period.
- Pending update per cycle, when ena=1, in priority order:
  1. clear_i=1 → pending=0, overflow=0. Clear beats set and service.
  2. Otherwise, clr = one-hot of the highest set pending bit if svc_ack_i=1 and irq_o=1, else 0.
  3. set = rise & mask_i.
  4. pending_next = (pending & ~clr) | set. Set wins over clear on the same bit, so a fresh edge on the line just serviced re-arms it.
  5. overflow_next = overflow | (set & pending & ~clr).
- svc_ack_i while irq_o=0: no effect, no error.
- ena=0: pending and overflow hold. svc_ack_i and clear_i are ignored.
- irq_o and code_o are combinational decodes of the pending register only, with zero added latency. They never depend directly on req_in, mask_i or svc_ack_i.
- Mask: mask_i gates capture only. Clearing a mask bit does not drop an already-pending bit.
- Reset mid-operation: asynchronous return to the reset values. Synchroniser history is lost, so a line held high across reset deassertion produces a rising edge 2 (SYNC_STAGES) cycles later and is captured if masked in.

Decomposition:
- Shared package: WIDTH default, CODE_NONE = 8'hF0, and a function returning the highest-set index / one-hot of a WIDTH vector. The encoder and this block use the same function.
- One sub-module: irq_sync_edge. It is a per-vector SYNC_STAGES synchroniser plus rise detector, parameterised by WIDTH and SYNC_STAGES, with ports clk, rst_n, d, rise.
- Pending/overflow/service logic stays in the top module.

Test Plan:
- Reset, then req_in=16'h0000 → pending_o=0, irq_o=0, code_o=8'hF0; same values after rst_n is asserted mid-run.
- mask_i=16'hFFFF; raise req_in[5] and req_in[12] in the same cycle → both pending at E2, code_o=8'h0C. First svc_ack_i → code_o=8'h05. Second svc_ack_i → code_o=8'hF0, irq_o=0.
- mask_i=16'hFFFE; pulse req_in[0] for 3 cycles → pending_o stays 0. Unmask, then hold req_in[0] high → no capture (no new edge).
- req_in[3] pending; drop and re-raise it → overflow_o[3]=1 and pending_o[3] stays 1. clear_i → pending_o=0, overflow_o=0.
- Edge on bit 9 lands in the same cycle as svc_ack_i clearing bit 9 → pending_o[9]=1 after the edge, overflow_o[9]=0.
- ena=0 with bit 7 pending: pulse svc_ack_i and clear_i, and raise req_in[2] → pending_o unchanged (=16'h0080). Set ena=1 → bit 2 is never captured.

Source files
------------

// File: rtl/irq_pending_capture_pkg.sv
// rtl/irq_pending_capture_pkg.sv - shared constants and highest-set-bit helper for the irq capture path
//
// Purpose: constants and a priority helper shared by the capture stage and the
// downstream 16-input encoder, so both agree on which request is "highest".
//   WIDTH_DEF  default number of request lines
//   CODE_NONE  encoder code presented when nothing is pending
//   hi_t       result of find_highest: found flag, index, one-hot of that index
package irq_pending_capture_pkg;

  localparam int         WIDTH_DEF = 16;
  localparam logic [7:0] CODE_NONE = 8'hF0;

  typedef struct packed {
    logic        found;
    logic [3:0]  idx;
    logic [15:0] onehot;
  } hi_t;

  // Ascending scan: the last set bit seen is the highest, so it wins.
  function automatic hi_t find_highest(input logic [15:0] v);
    hi_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        r.found     = 1'b1;
        r.idx       = i[3:0];
        r.onehot    = '0;
        r.onehot[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-bit multi-flop synchroniser with rising-edge detect
//
// Purpose: bring WIDTH asynchronous lines into the clk domain and flag rising edges.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   d      raw asynchronous inputs
//   rise   one-cycle pulse per bit when the synchronised value goes 0 -> 1
module irq_sync_edge #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s_d_q;
  logic [WIDTH-1:0] s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      s_d_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_d_q <= s;
    end
  end

  assign rise = s & ~s_d_q;

endmodule

// File: rtl/irq_pending_capture.sv
// rtl/irq_pending_capture.sv - sticky pending/overflow capture with service handshake
//
// Purpose: capture masked rising edges of WIDTH request lines into a sticky
// pending vector, expose the highest pending request as an encoder code, and
// retire it on svc_ack_i.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   ena         low freezes pending/overflow (edges during this time are lost)
//   req_in      raw asynchronous requests, bit WIDTH-1 highest priority
//   mask_i      1 = edge may set pending
//   svc_ack_i   pulse: highest pending request serviced
//   clear_i     synchronous clear of pending and overflow
//   pending_o   registered pending vector
//   irq_o       OR of pending_o
//   code_o      {4'h0, highest pending index}, CODE_NONE when idle
//   overflow_o  sticky: edge arrived on an already-pending line
module irq_pending_capture
  import irq_pending_capture_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask_i,
  input  logic             svc_ack_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o,
  output logic [7:0]       code_o,
  output logic [WIDTH-1:0] overflow_o
);

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] overflow_q, overflow_d;
  logic [WIDTH-1:0] set_v, clr_v;
  logic [15:0]      pend_ext;
  hi_t              hi;

  irq_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_in),
    .rise  (rise)
  );

  // Helper works on a fixed 16-bit vector; zero-extend narrower configs.
  always_comb begin
    pend_ext               = '0;
    pend_ext[WIDTH-1:0]    = pending_q;
    hi                     = find_highest(pend_ext);
  end

  always_comb begin
    set_v      = rise & mask_i;
    clr_v      = (svc_ack_i && hi.found) ? hi.onehot[WIDTH-1:0] : '0;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (ena) begin
      if (clear_i) begin
        pending_d  = '0;
        overflow_d = '0;
      end else begin
        // set after clear: a fresh edge on the line just serviced re-arms it
        pending_d  = (pending_q & ~clr_v) | set_v;
        overflow_d = overflow_q | (set_v & pending_q & ~clr_v);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;
  assign irq_o      = hi.found;
  assign code_o     = hi.found ? {4'h0, hi.idx} : CODE_NONE;

endmodule

// File: tb/tb_irq_pending_capture.sv
// tb/tb_irq_pending_capture.sv - directed self-checking bench for irq_pending_capture
module tb_irq_pending_capture;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [15:0] req_in;
  logic [15:0] mask_i;
  logic        svc_ack_i;
  logic        clear_i;
  logic [15:0] pending_o;
  logic        irq_o;
  logic [7:0]  code_o;
  logic [15:0] overflow_o;

  int total = 0;
  int bad   = 0;

  irq_pending_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .req_in     (req_in),
    .mask_i     (mask_i),
    .svc_ack_i  (svc_ack_i),
    .clear_i    (clear_i),
    .pending_o  (pending_o),
    .irq_o      (irq_o),
    .code_o     (code_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; req_in = 16'h0000; mask_i = 16'hFFFF;
    svc_ack_i = 1'b0; clear_i = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL reset_pending got=%h exp=0000", pending_o); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    total++; if (code_o !== 8'hF0) begin bad++; $display("FAIL reset_code got=%h exp=f0", code_o); end
    total++; if (overflow_o !== 16'h0000) begin bad++; $display("FAIL reset_overflow got=%h exp=0000", overflow_o); end
  endtask

  task automatic test_two_lines;
    mask_i = 16'hFFFF;
    req_in = 16'h1020;
    step(2);
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL latency_early got=%h exp=0000", pending_o); end
    step(1);
    total++; if (pending_o !== 16'h1020) begin bad++; $display("FAIL two_pending got=%h exp=1020", pending_o); end
    total++; if (code_o !== 8'h0C) begin bad++; $display("FAIL two_code got=%h exp=0c", code_o); end
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL two_irq got=%b exp=1", irq_o); end
    svc_ack_i = 1'b1; step(1); svc_ack_i = 1'b0;
    total++; if (code_o !== 8'h05) begin bad++; $display("FAIL ack1_code got=%h exp=05", code_o); end
    total++; if (pending_o !== 16'h0020) begin bad++; $display("FAIL ack1_pending got=%h exp=0020", pending_o); end
    svc_ack_i = 1'b1; step(1); svc_ack_i = 1'b0;
    total++; if (code_o !== 8'hF0) begin bad++; $display("FAIL ack2_code got=%h exp=f0", code_o); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ack2_irq got=%b exp=0", irq_o); end
    svc_ack_i = 1'b1; step(1); svc_ack_i = 1'b0;
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL idle_ack got=%h exp=0000", pending_o); end
    req_in = 16'h0000;
    step(3);
  endtask

  task automatic test_mask;
    mask_i = 16'hFFFE;
    req_in = 16'h0001;
    step(3);
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL masked_edge got=%h exp=0000", pending_o); end
    mask_i = 16'hFFFF;
    step(4);
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL unmask_held got=%h exp=0000", pending_o); end
    req_in = 16'h0000;
    step(3);
  endtask

  task automatic test_overflow;
    req_in = 16'h0008;
    step(3);
    total++; if (pending_o !== 16'h0008) begin bad++; $display("FAIL ovf_first got=%h exp=0008", pending_o); end
    total++; if (overflow_o !== 16'h0000) begin bad++; $display("FAIL ovf_none got=%h exp=0000", overflow_o); end
    req_in = 16'h0000;
    step(2);
    req_in = 16'h0008;
    step(3);
    total++; if (overflow_o !== 16'h0008) begin bad++; $display("FAIL ovf_set got=%h exp=0008", overflow_o); end
    total++; if (pending_o !== 16'h0008) begin bad++; $display("FAIL ovf_pending got=%h exp=0008", pending_o); end
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL clr_pending got=%h exp=0000", pending_o); end
    total++; if (overflow_o !== 16'h0000) begin bad++; $display("FAIL clr_overflow got=%h exp=0000", overflow_o); end
    req_in = 16'h0000;
    step(3);
  endtask

  task automatic test_back_to_back;
    req_in = 16'h0200;
    step(3);
    total++; if (pending_o !== 16'h0200) begin bad++; $display("FAIL b2b_first got=%h exp=0200", pending_o); end
    req_in = 16'h0000;
    step(2);
    req_in = 16'h0200;
    step(2);
    svc_ack_i = 1'b1; step(1); svc_ack_i = 1'b0;
    total++; if (pending_o !== 16'h0200) begin bad++; $display("FAIL b2b_rearm got=%h exp=0200", pending_o); end
    total++; if (overflow_o !== 16'h0000) begin bad++; $display("FAIL b2b_overflow got=%h exp=0000", overflow_o); end
    req_in = 16'h0000;
    step(3);
    svc_ack_i = 1'b1; step(1); svc_ack_i = 1'b0;
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL b2b_drain got=%h exp=0000", pending_o); end
  endtask

  task automatic test_ena;
    req_in = 16'h0080;
    step(3);
    total++; if (pending_o !== 16'h0080) begin bad++; $display("FAIL ena_setup got=%h exp=0080", pending_o); end
    ena = 1'b0;
    svc_ack_i = 1'b1; step(1); svc_ack_i = 1'b0;
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    req_in = 16'h0084;
    step(4);
    total++; if (pending_o !== 16'h0080) begin bad++; $display("FAIL ena_hold got=%h exp=0080", pending_o); end
    total++; if (code_o !== 8'h07) begin bad++; $display("FAIL ena_code got=%h exp=07", code_o); end
    ena = 1'b1;
    step(3);
    total++; if (pending_o !== 16'h0080) begin bad++; $display("FAIL ena_lost got=%h exp=0080", pending_o); end
  endtask

  task automatic test_reset_midrun;
    // lines 7 and 2 still held high; reset asserted between edges
    rst_n = 1'b0;
    #1;
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL midrst_pending got=%h exp=0000", pending_o); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", irq_o); end
    total++; if (code_o !== 8'hF0) begin bad++; $display("FAIL midrst_code got=%h exp=f0", code_o); end
    step(1);
    rst_n = 1'b1;
    step(2);
    total++; if (pending_o !== 16'h0000) begin bad++; $display("FAIL postrst_early got=%h exp=0000", pending_o); end
    step(1);
    total++; if (pending_o !== 16'h0084) begin bad++; $display("FAIL postrst_capture got=%h exp=0084", pending_o); end
    total++; if (code_o !== 8'h07) begin bad++; $display("FAIL postrst_code got=%h exp=07", code_o); end
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_mask();
    test_overflow();
    test_back_to_back();
    test_ena();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
